// File: rtl/cache_victim_sel.sv
// cache_victim_sel: victim-way selection for the cache refill path.
// On a miss it chooses the lowest free way. If no way is free, it probes
// ways from a pseudo-random base taken from a 5-bit LFSR and skips locked
// ways. The chosen way is offered through a valid/ready handshake and is
// then held until the refill completes.
module cache_victim_sel #(
    parameter int SET_SIZE  = 4,
    parameter int WAY_WIDTH = $clog2(SET_SIZE)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [SET_SIZE-1:0]  req_valid_ways,
    input  logic [SET_SIZE-1:0]  req_lock_ways,
    output logic                 victim_valid,
    input  logic                 victim_ready,
    output logic [WAY_WIDTH-1:0] victim_way,
    output logic                 victim_evict,
    output logic                 victim_fail,
    input  logic                 refill_done,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PICK      = 2'd1,
        OFFER     = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t                state_reg;
    logic [SET_SIZE-1:0]   valid_reg;
    logic [SET_SIZE-1:0]   lock_reg;
    logic [4:0]            lfsr_reg;
    logic [WAY_WIDTH-1:0]  base_reg;
    logic [WAY_WIDTH-1:0]  probe_k_reg;

    logic                  req_ready_reg;
    logic                  victim_valid_reg;
    logic [WAY_WIDTH-1:0]  victim_way_reg;
    logic                  victim_evict_reg;
    logic                  victim_fail_reg;
    logic                  busy_reg;

    logic [SET_SIZE-1:0]   free_ways;
    logic                  any_free;
    logic [WAY_WIDTH-1:0]  lowest_free;
    logic [WAY_WIDTH-1:0]  probe_way;
    logic                  probe_locked;
    logic                  probe_last;
    logic [4:0]            lfsr_next;

    // A way is free when it holds no data and is not locked.
    generate
        for (genvar gi = 0; gi < SET_SIZE; gi++) begin : g_free
            assign free_ways[gi] = ~valid_reg[gi] & ~lock_reg[gi];
        end
    endgenerate

    assign any_free = |free_ways;

    // Priority encoder: scanning downward leaves the lowest free index.
    always_comb begin
        lowest_free = '0;
        for (int i = SET_SIZE - 1; i >= 0; i--) begin
            if (free_ways[i]) begin
                lowest_free = WAY_WIDTH'(i);
            end
        end
    end

    // SET_SIZE is a power of two, so the natural wrap of the adder is mod SET_SIZE.
    assign probe_way    = base_reg + probe_k_reg;
    assign probe_locked = lock_reg[probe_way];
    assign probe_last   = (probe_k_reg == WAY_WIDTH'(SET_SIZE - 1));
    assign lfsr_next    = {lfsr_reg[0], lfsr_reg[4], lfsr_reg[3] ^ lfsr_reg[0], lfsr_reg[2:1]};

    // Controller FSM with registered outputs; the LFSR moves only when a result is consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            valid_reg        <= '0;
            lock_reg         <= '0;
            lfsr_reg         <= 5'h01;
            base_reg         <= '0;
            probe_k_reg      <= '0;
            req_ready_reg    <= 1'b1;
            victim_valid_reg <= 1'b0;
            victim_way_reg   <= '0;
            victim_evict_reg <= 1'b0;
            victim_fail_reg  <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        valid_reg     <= req_valid_ways;
                        lock_reg      <= req_lock_ways;
                        base_reg      <= lfsr_reg[WAY_WIDTH-1:0];
                        probe_k_reg   <= '0;
                        req_ready_reg <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= PICK;
                    end
                end
                PICK: begin
                    if (any_free) begin
                        victim_way_reg   <= lowest_free;
                        victim_evict_reg <= 1'b0;
                        victim_fail_reg  <= 1'b0;
                        victim_valid_reg <= 1'b1;
                        state_reg        <= OFFER;
                    end else if (!probe_locked) begin
                        victim_way_reg   <= probe_way;
                        victim_evict_reg <= 1'b1;
                        victim_fail_reg  <= 1'b0;
                        victim_valid_reg <= 1'b1;
                        state_reg        <= OFFER;
                    end else if (probe_last) begin
                        victim_way_reg   <= '0;
                        victim_evict_reg <= 1'b0;
                        victim_fail_reg  <= 1'b1;
                        victim_valid_reg <= 1'b1;
                        state_reg        <= OFFER;
                    end else begin
                        probe_k_reg <= probe_k_reg + WAY_WIDTH'(1);
                    end
                end
                OFFER: begin
                    if (victim_ready) begin
                        victim_valid_reg <= 1'b0;
                        lfsr_reg         <= lfsr_next;
                        if (victim_fail_reg) begin
                            req_ready_reg <= 1'b1;
                            busy_reg      <= 1'b0;
                            state_reg     <= IDLE;
                        end else begin
                            state_reg <= WAIT_DONE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (refill_done) begin
                        req_ready_reg <= 1'b1;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_reg;
    assign victim_valid = victim_valid_reg;
    assign victim_way   = victim_way_reg;
    assign victim_evict = victim_evict_reg;
    assign victim_fail  = victim_fail_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_cache_victim_sel.sv
// Testbench for cache_victim_sel: scoreboard of expected victims computed
// from an independent reference model, compared when the DUT offers a result.
module tb_cache_victim_sel;

    localparam int N  = 4;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [N-1:0]  req_valid_ways = '0;
    logic [N-1:0]  req_lock_ways = '0;
    logic          victim_valid;
    logic          victim_ready = 1'b0;
    logic [WW-1:0] victim_way;
    logic          victim_evict;
    logic          victim_fail;
    logic          refill_done = 1'b0;
    logic          busy;

    cache_victim_sel #(.SET_SIZE(N), .WAY_WIDTH(WW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_valid_ways (req_valid_ways),
        .req_lock_ways  (req_lock_ways),
        .victim_valid   (victim_valid),
        .victim_ready   (victim_ready),
        .victim_way     (victim_way),
        .victim_evict   (victim_evict),
        .victim_fail    (victim_fail),
        .refill_done    (refill_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] way;
        logic          evict;
        logic          fail;
        int            lat;
    } exp_t;

    exp_t       sb_q[$];
    logic [4:0] model_lfsr = 5'h01;
    int         checks = 0;
    int         failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] lfsr_step(input logic [4:0] q);
        return {q[0], q[4], q[3] ^ q[0], q[2:1]};
    endfunction

    // Reference: lat counts clock edges from the acceptance edge to the edge
    // that first presents victim_valid.
    function automatic exp_t predict(input logic [N-1:0] v, input logic [N-1:0] l,
                                     input logic [WW-1:0] base);
        exp_t e;
        logic [N-1:0] free_m;
        e.way = '0; e.evict = 1'b0; e.fail = 1'b0; e.lat = 1;
        free_m = ~v & ~l;
        if (free_m != '0) begin
            for (int i = 0; i < N; i++) begin
                if (free_m[i]) begin
                    e.way = WW'(i);
                    return e;
                end
            end
        end
        for (int k = 0; k < N; k++) begin
            int w;
            w = (int'(base) + k) % N;
            if (!l[w]) begin
                e.way = WW'(w); e.evict = 1'b1; e.lat = 1 + k;
                return e;
            end
        end
        e.fail = 1'b1; e.lat = N;
        return e;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_val({tag, "_victim_valid"}, 32'(victim_valid), 32'd0);
        check_val({tag, "_victim_way"}, 32'(victim_way), 32'd0);
        check_val({tag, "_victim_evict"}, 32'(victim_evict), 32'd0);
        check_val({tag, "_victim_fail"}, 32'(victim_fail), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic reset_dut();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        model_lfsr = 5'h01;
        sb_q.delete();
    endtask

    task automatic run_req(input logic [N-1:0] v, input logic [N-1:0] l, input int stall,
                           input bit refill_in_offer, input bit req_in_wait);
        exp_t e;
        int   lat;
        @(negedge clk);
        check_val("accept_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_valid_ways = v; req_lock_ways = l;
        @(posedge clk);
        sb_q.push_back(predict(v, l, model_lfsr[WW-1:0]));
        #1;
        req_valid = 1'b0;
        req_valid_ways = N'($urandom);
        req_lock_ways = N'($urandom);
        check_val("pick_busy", 32'(busy), 32'd1);
        check_val("pick_req_ready", 32'(req_ready), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!victim_valid && lat < 64);
        e = sb_q.pop_front();
        check_val("latency", 32'(lat), 32'(e.lat));
        check_val("way", 32'(victim_way), 32'(e.way));
        check_val("evict", 32'(victim_evict), 32'(e.evict));
        check_val("fail", 32'(victim_fail), 32'(e.fail));
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            refill_done = refill_in_offer;
            @(posedge clk);
            #1;
            refill_done = 1'b0;
            check_val("stall_valid", 32'(victim_valid), 32'd1);
            check_val("stall_way", 32'(victim_way), 32'(e.way));
            check_val("stall_evict", 32'(victim_evict), 32'(e.evict));
        end
        @(negedge clk);
        victim_ready = 1'b1;
        @(posedge clk);
        model_lfsr = lfsr_step(model_lfsr);
        #1;
        victim_ready = 1'b0;
        check_val("post_hs_valid", 32'(victim_valid), 32'd0);
        if (e.fail) begin
            check_val("fail_ret_ready", 32'(req_ready), 32'd1);
            check_val("fail_ret_busy", 32'(busy), 32'd0);
        end else begin
            check_val("wait_ready", 32'(req_ready), 32'd0);
            check_val("wait_busy", 32'(busy), 32'd1);
            check_val("wait_way_held", 32'(victim_way), 32'(e.way));
            if (req_in_wait) begin
                repeat (2) begin
                    @(negedge clk);
                    req_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    check_val("wait_ignore_req", 32'(req_ready), 32'd0);
                    check_val("wait_no_valid", 32'(victim_valid), 32'd0);
                end
                req_valid = 1'b0;
            end
            @(negedge clk);
            refill_done = 1'b1;
            @(posedge clk);
            #1;
            refill_done = 1'b0;
            check_val("done_ready", 32'(req_ready), 32'd1);
            check_val("done_busy", 32'(busy), 32'd0);
        end
        $display("txn valid=%b lock=%b way=%0d evict=%0b fail=%0b lat=%0d lfsr_after=%h",
                 v, l, victim_way, victim_evict, victim_fail, lat, model_lfsr);
    endtask

    logic [N-1:0] tbl_v[4] = '{4'b0000, 4'b0001, 4'b1111, 4'b0000};
    logic [N-1:0] tbl_l[4] = '{4'b0000, 4'b0010, 4'b1110, 4'b1111};

    initial begin
        int cnt;
        reset_dut();
        run_req(4'b1011, 4'b0000, 0, 1'b0, 1'b0);   // free path -> way 2
        reset_dut();
        run_req(4'hF, 4'h0, 0, 1'b0, 1'b0);         // random, base 1 -> way 1
        run_req(4'hF, 4'b0001, 0, 1'b0, 1'b0);      // base 0 locked -> way 1
        run_req(4'hF, 4'hF, 0, 1'b0, 1'b0);         // all locked -> fail
        run_req(4'hF, 4'h0, 3, 1'b1, 1'b1);         // backpressure, ignored pulses
        for (int i = 0; i < 4; i++) begin
            run_req(tbl_v[i], tbl_l[i], i % 2, 1'b0, 1'b0);
        end

        // Reset while PICK is at probe 2.
        @(negedge clk);
        req_valid = 1'b1; req_valid_ways = 4'hF; req_lock_ways = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_val("mid_pick_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_pick");
        @(negedge clk);
        resetn = 1'b1;
        model_lfsr = 5'h01;

        // Reset while in WAIT_DONE.
        @(negedge clk);
        req_valid = 1'b1; req_valid_ways = 4'hF; req_lock_ways = 4'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cnt = 0;
        while (!victim_valid && cnt < 64) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check_val("pre_wait_valid", 32'(victim_valid), 32'd1);
        @(negedge clk);
        victim_ready = 1'b1;
        @(posedge clk);
        #1;
        victim_ready = 1'b0;
        check_val("in_wait_way", 32'(victim_way), 32'd1);
        check_val("in_wait_busy", 32'(busy), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        check_reset_outputs("async_wait");
        @(negedge clk);
        resetn = 1'b1;
        model_lfsr = 5'h01;

        run_req(4'hF, 4'h0, 0, 1'b0, 1'b0);         // LFSR restarted -> way 1

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
